// File: rtl/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//
// Two-master OBI arbiter that shares one memory port between an
// instruction fetch port (read-only) and a data port. Responses come back
// in order, so a small FIFO of source IDs tells us which master owns each
// returning mem_rvalid_i.
//
// Configuration macro:
//   TB_MEM_ARB_ROUND_ROBIN_EN  defined   -> round-robin between contenders
//                              undefined -> fixed priority, data beats instr
//
// Parameters:
//   ADDR_WIDTH       address width of every port
//   MAX_OUTSTANDING  depth of the response-routing FIFO (1..4)
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   instr_req_i/addr_i                instruction request
//   instr_gnt_o/rvalid_o/rdata_o      instruction grant and response
//   data_req_i/addr_i/we_i/be_i/wdata_i  data request
//   data_gnt_o/rvalid_o/rdata_o       data grant and response
//   mem_req_o/addr_o/we_o/be_o/wdata_o   muxed request to shared memory
//   mem_gnt_i/rvalid_i/rdata_i        memory grant and in-order response
// ---------------------------------------------------------------------------
module tb_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  instr_req_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,

    input  logic                  data_req_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,

    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_be_o,
    output logic [31:0]           mem_wdata_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_t;

    localparam logic [2:0] MAX_COUNT = 3'(MAX_OUTSTANDING);
    localparam logic [1:0] LAST_IDX  = 2'(MAX_OUTSTANDING - 1);

    // Storage is always four entries so a 2-bit pointer indexes it cleanly;
    // only the first MAX_OUTSTANDING entries are ever used.
    src_t       fifo_id [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;

    src_t       lock_src;
    logic       locked;
    src_t       winner;
    logic       any_req;
    logic       fifo_blocked;
    logic       handshake;
    logic       pop;

`ifdef TB_MEM_ARB_ROUND_ROBIN_EN
    src_t       last_src;
`endif

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == LAST_IDX) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Pick this cycle's winner. A stalled request (lock) keeps ownership
    // of the memory port so the request fields stay stable until granted.
    always_comb begin
        winner = SRC_INSTR;
        if (locked) begin
            winner = lock_src;
        end else if (instr_req_i && data_req_i) begin
`ifdef TB_MEM_ARB_ROUND_ROBIN_EN
            winner = (last_src == SRC_DATA) ? SRC_INSTR : SRC_DATA;
`else
            winner = SRC_DATA;
`endif
        end else if (data_req_i) begin
            winner = SRC_DATA;
        end
    end

    // A full FIFO only blocks when nothing retires this cycle; a returning
    // response frees its slot in time for a same-cycle push.
    assign any_req      = instr_req_i || data_req_i;
    assign fifo_blocked = (count == MAX_COUNT) && !mem_rvalid_i;
    assign mem_req_o    = any_req && !fifo_blocked && !rst_i;
    assign handshake    = mem_req_o && mem_gnt_i;
    assign pop          = mem_rvalid_i && (count != 3'd0) && !rst_i;

    assign mem_addr_o  = (winner == SRC_DATA) ? data_addr_i : instr_addr_i;
    assign mem_we_o    = (winner == SRC_DATA) && data_we_i;
    assign mem_be_o    = (winner == SRC_DATA) ? data_be_i : 4'hF;
    assign mem_wdata_o = (winner == SRC_DATA) ? data_wdata_i : 32'h0;

    assign instr_gnt_o = handshake && (winner == SRC_INSTR);
    assign data_gnt_o  = handshake && (winner == SRC_DATA);

    assign instr_rvalid_o = pop && (fifo_id[rd_ptr] == SRC_INSTR);
    assign data_rvalid_o  = pop && (fifo_id[rd_ptr] == SRC_DATA);

    assign instr_rdata_o = mem_rdata_i;
    assign data_rdata_o  = mem_rdata_i;

    // FIFO payload needs no reset: count alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            fifo_id[wr_ptr] <= winner;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave count alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (handshake) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (handshake && !pop) begin
                count <= count + 3'd1;
            end else if (!handshake && pop) begin
                count <= count - 3'd1;
            end
        end
    end

    // Lock on a request the memory did not accept; release on handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            locked   <= 1'b0;
            lock_src <= SRC_INSTR;
        end else if (mem_req_o && !mem_gnt_i) begin
            locked   <= 1'b1;
            lock_src <= winner;
        end else if (handshake) begin
            locked   <= 1'b0;
        end
    end

`ifdef TB_MEM_ARB_ROUND_ROBIN_EN
    // Remember who last completed a handshake so the other side wins next
    // time both are asking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_src <= SRC_DATA;
        end else if (handshake) begin
            last_src <= winner;
        end
    end
`endif

endmodule
